// File: rtl/display_bcd_varredura.sv
// Binary to packed BCD (sequential double dabble) driving a time-multiplexed 7-segment display.
// Latency: LARGURA+1 edges from the accepted load to the new bcd/pronto. Scan output is combinational from registers.
// Backpressure: loads arriving while ocupado=1 are dropped, not queued. Optional BLANK_ZEROS_EN blanks leading zeros.
module display_bcd_varredura #(
    parameter int LARGURA       = 6,
    parameter int DIGITOS       = 2,
    parameter int DIV_VARREDURA = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 carregar,
    input  logic [LARGURA-1:0]   entrada,
    output logic                 ocupado,
    output logic                 pronto,
    output logic [4*DIGITOS-1:0] bcd,
    output logic [DIGITOS-1:0]   anodos,
    output logic [6:0]           segmentos
);

    localparam int BW = 4 * DIGITOS;
    localparam int CW = $clog2(LARGURA + 1);
    localparam int PW = (DIV_VARREDURA > 1) ? $clog2(DIV_VARREDURA) : 1;
    localparam int IW = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;

    // The display must be wide enough to hold the largest input value.
    if (64'(10) ** DIGITOS < 64'(2) ** LARGURA) begin : g_capacidade
        $error("display_bcd_varredura: DIGITOS too small for LARGURA");
    end

    typedef enum logic {OCIOSO, CONVERTE} estado_t;

    estado_t           estado, prox_estado;
    logic [LARGURA-1:0] desloc;
    logic [BW-1:0]     trabalho;
    logic [BW-1:0]     ajustado;
    logic [BW-1:0]     deslocado;
    logic [CW-1:0]     contador;
    logic              ultimo;
    logic [PW-1:0]     presc;
    logic [IW-1:0]     indice;
    logic [3:0]        digito;
    logic              apagar;
    logic              zeros_acima;

    assign ultimo = (contador == CW'(LARGURA - 1));

    // FSM state register; reset aborts any conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) estado <= OCIOSO;
        else     estado <= prox_estado;
    end

    // Next-state: a load starts a conversion, the last shift returns to idle.
    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSO:   if (carregar) prox_estado = CONVERTE;
            CONVERTE: if (ultimo)   prox_estado = OCIOSO;
            default:  prox_estado = OCIOSO;
        endcase
    end

    // Add-3 correction on every work nibble >= 5, then shift the next binary bit in.
    always_comb begin
        ajustado = trabalho;
        for (int i = 0; i < DIGITOS; i++) begin
            if (trabalho[4*i +: 4] >= 4'd5)
                ajustado[4*i +: 4] = trabalho[4*i +: 4] + 4'd3;
        end
        deslocado = {ajustado[BW-2:0], desloc[LARGURA-1]};
    end

    // Conversion datapath; bcd only changes when a conversion completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            desloc   <= '0;
            trabalho <= '0;
            contador <= '0;
            bcd      <= '0;
            ocupado  <= 1'b0;
            pronto   <= 1'b0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (carregar) begin
                        desloc   <= entrada;
                        trabalho <= '0;
                        contador <= '0;
                        ocupado  <= 1'b1;
                    end
                end
                CONVERTE: begin
                    trabalho <= deslocado;
                    desloc   <= desloc << 1;
                    contador <= contador + CW'(1);
                    if (ultimo) begin
                        bcd     <= deslocado;
                        pronto  <= 1'b1;
                        ocupado <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Free-running scan: prescaler sets dwell time, index walks the digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc  <= '0;
            indice <= '0;
        end else if (presc == PW'(DIV_VARREDURA - 1)) begin
            presc  <= '0;
            indice <= (indice == IW'(DIGITOS - 1)) ? '0 : indice + IW'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Select the lit digit and its anode.
    always_comb begin
        digito = 4'd0;
        anodos = '0;
        for (int i = 0; i < DIGITOS; i++) begin
            anodos[i] = (indice == IW'(i));
            if (indice == IW'(i)) digito = bcd[4*i +: 4];
        end
    end

`ifdef BLANK_ZEROS_EN
    // Blank a non-units digit when it and every digit above it are zero.
    always_comb begin
        apagar      = 1'b0;
        zeros_acima = 1'b1;
        for (int i = DIGITOS - 1; i >= 1; i--) begin
            zeros_acima = zeros_acima && (bcd[4*i +: 4] == 4'd0);
            if ((indice == IW'(i)) && zeros_acima) apagar = 1'b1;
        end
    end
`else
    // All digits always shown, leading zeros included.
    always_comb begin
        apagar      = 1'b0;
        zeros_acima = 1'b0;
    end
`endif

    function automatic logic [6:0] decodifica(input logic [3:0] d);
        case (d)
            4'd0:    decodifica = 7'h3F;
            4'd1:    decodifica = 7'h06;
            4'd2:    decodifica = 7'h5B;
            4'd3:    decodifica = 7'h4F;
            4'd4:    decodifica = 7'h66;
            4'd5:    decodifica = 7'h6D;
            4'd6:    decodifica = 7'h7D;
            4'd7:    decodifica = 7'h07;
            4'd8:    decodifica = 7'h7F;
            4'd9:    decodifica = 7'h6F;
            default: decodifica = 7'h00;
        endcase
    endfunction

    // Segment pattern of the selected digit.
    always_comb begin
        segmentos = apagar ? 7'h00 : decodifica(digito);
    end

endmodule

// File: tb/tb_display_bcd_varredura.sv
module tb_display_bcd_varredura;
    localparam int L = 6;
    localparam int D = 2;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst, carregar;
    logic [L-1:0] entrada;
    logic ocupado, pronto;
    logic [4*D-1:0] bcd;
    logic [D-1:0] anodos;
    logic [6:0] segmentos;

    int total = 0;
    int bad = 0;

    display_bcd_varredura #(.LARGURA(L), .DIGITOS(D), .DIV_VARREDURA(DIV)) dut (
        .clk(clk), .rst(rst), .carregar(carregar), .entrada(entrada),
        .ocupado(ocupado), .pronto(pronto), .bcd(bcd),
        .anodos(anodos), .segmentos(segmentos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nome, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nome, act, exp, $time);
        end
    endtask

    function automatic int to_bcd(input int v);
        int r = 0;
        for (int d = 0; d < D; d++) begin
            r = r | ((v % 10) << (4 * d));
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int seg_of(input int d);
        case (d)
            0: return 'h3F; 1: return 'h06; 2: return 'h5B; 3: return 'h4F;
            4: return 'h66; 5: return 'h6D; 6: return 'h7D; 7: return 'h07;
            8: return 'h7F; 9: return 'h6F;
            default: return 0;
        endcase
    endfunction

    // Behavioural model: busy window countdown, decimal conversion, scan from elapsed cycles.
    bit m_valid = 0;
    bit m_busy, m_pronto;
    int m_left, m_val, m_bcd, m_scan;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1; m_busy = 0; m_pronto = 0; m_left = 0; m_bcd = 0; m_scan = 0;
        end else if (m_valid) begin
            m_pronto = 0;
            m_scan++;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_bcd = to_bcd(m_val); m_pronto = 1;
                end
            end else if (carregar) begin
                m_busy = 1; m_left = L; m_val = int'(entrada);
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            int idx, dig, seg;
            idx = (m_scan / DIV) % D;
            dig = (m_bcd >> (4 * idx)) & 15;
            seg = seg_of(dig);
`ifdef BLANK_ZEROS_EN
            if (idx > 0 && (m_bcd >> (4 * idx)) == 0) seg = 0;
`endif
            chk("m_ocupado", int'(ocupado), int'(m_busy));
            chk("m_pronto", int'(pronto), int'(m_pronto));
            chk("m_bcd", int'(bcd), m_bcd);
            chk("m_anodos", int'(anodos), 1 << idx);
            chk("m_segmentos", int'(segmentos), seg);
        end
    end

    task automatic load(input int v);
        carregar = 1'b1;
        entrada = L'(v);
        @(negedge clk);
        carregar = 1'b0;
    endtask

    // Watch n cycles from the current negedge: busy count, pronto count, first pronto index.
    task automatic watch(input int n, output int nb, output int np, output int pk);
        nb = 0; np = 0; pk = -1;
        for (int k = 0; k < n; k++) begin
            if (ocupado) nb++;
            if (pronto) begin np++; if (pk < 0) pk = k; end
            @(negedge clk);
        end
    endtask

    initial begin
        int nb, np, pk, s1, s2, saw12, pk1, pk2, bcd_first;
        rst = 1'b1; carregar = 1'b0; entrada = '0;
        repeat (2) @(negedge clk);
        chk("rst_ocupado", int'(ocupado), 0);
        chk("rst_pronto", int'(pronto), 0);
        chk("rst_bcd", int'(bcd), 'h00);
        chk("rst_anodos", int'(anodos), 'b01);
        chk("rst_seg", int'(segmentos), 'h3F);
        rst = 1'b0;

        // Free-running scan wrap.
        for (int k = 0; k < 9; k++) begin
            chk("scan_anodos", int'(anodos), (k < 4 || k == 8) ? 1 : 2);
            @(negedge clk);
        end

        // Load 45.
        load(45);
        watch(10, nb, np, pk);
        chk("t45_busy_cycles", nb, 6);
        chk("t45_pronto_cnt", np, 1);
        chk("t45_pronto_pos", pk, 6);
        chk("t45_bcd", int'(bcd), 'h45);
        s1 = 0; s2 = 0;
        for (int k = 0; k < 8; k++) begin
            if (anodos == 2'b01) begin s1++; chk("t45_seg0", int'(segmentos), 'h6D); end
            if (anodos == 2'b10) begin s2++; chk("t45_seg1", int'(segmentos), 'h66); end
            @(negedge clk);
        end
        chk("t45_seen0", s1, 4);
        chk("t45_seen1", s2, 4);

        // Load 63 with loads during busy, including the final conversion edge.
        load(63);
        np = 0; saw12 = 0;
        for (int k = 0; k < 12; k++) begin
            if (k == 2 || k == 5) begin carregar = 1'b1; entrada = L'(12); end
            if (k == 3 || k == 6) carregar = 1'b0;
            if (pronto) np++;
            if (bcd == 8'h12) saw12++;
            @(negedge clk);
        end
        chk("t63_pronto_cnt", np, 1);
        chk("t63_bcd", int'(bcd), 'h63);
        chk("t63_saw12", saw12, 0);

        // Reset during conversion.
        load(45);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ocupado", int'(ocupado), 0);
        chk("abort_bcd", int'(bcd), 'h00);
        watch(10, nb, np, pk);
        chk("abort_pronto", np, 0);

        // Back-to-back: carregar held high, second load accepted at E(L+1).
        carregar = 1'b1; entrada = L'(9);
        @(negedge clk);
        entrada = '0;
        pk1 = -1; pk2 = -1; bcd_first = -1;
        for (int k = 0; k < 16; k++) begin
            if (k == 7) carregar = 1'b0;
            if (pronto) begin
                if (pk1 < 0) begin pk1 = k; bcd_first = int'(bcd); end
                else if (pk2 < 0) pk2 = k;
            end
            @(negedge clk);
        end
        chk("b2b_first_pos", pk1, 6);
        chk("b2b_first_bcd", bcd_first, 'h09);
        chk("b2b_second_pos", pk2, 13);
        chk("b2b_zero_bcd", int'(bcd), 'h00);

        // Load 7: leading digit zero.
        load(7);
        watch(10, nb, np, pk);
        chk("t7_bcd", int'(bcd), 'h07);
        s1 = 0; s2 = 0;
        for (int k = 0; k < 8; k++) begin
            if (anodos == 2'b01) begin s1++; chk("t7_seg0", int'(segmentos), 'h07); end
            if (anodos == 2'b10) begin
                s2++;
`ifdef BLANK_ZEROS_EN
                chk("t7_seg1", int'(segmentos), 'h00);
`else
                chk("t7_seg1", int'(segmentos), 'h3F);
`endif
            end
            @(negedge clk);
        end
        chk("t7_seen", s1 + s2, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
